// File: rtl/dma_ram_pkg.sv
// Shared helpers for the DMA RAM demux family: width derivation and parameter checks.
package dma_ram_pkg;

  // Port-index storage width; a single port still needs one (unused) bit.
  function automatic int port_idx_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/dma_ram_demux_rd_order_fifo.sv
// Per-segment ordering FIFO of port indices; pointers carry one extra wrap bit.
module dma_ram_demux_rd_order_fifo
  import dma_ram_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 1,
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = CW - 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [CW-1:0] wr_q, wr_d;
  logic [CW-1:0] rd_q, rd_d;

  always_comb begin
    wr_d = push_i ? wr_q + CW'(1) : wr_q;
    rd_d = pop_i  ? rd_q + CW'(1) : rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/dma_ram_demux_rd_ordered.sv
// Read-path DMA RAM demux: steers segmented read commands to PORTS RAMs and
// returns responses in command order per segment.
module dma_ram_demux_rd_ordered
  import dma_ram_pkg::*;
#(
  parameter int PORTS           = 2,
  parameter int SEG_COUNT       = 2,
  parameter int SEG_DATA_WIDTH  = 64,
  parameter int SEG_ADDR_WIDTH  = 8,
  parameter int S_RAM_SEL_WIDTH = 2,
  parameter int M_RAM_SEL_WIDTH = S_RAM_SEL_WIDTH + $clog2(PORTS),
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [SEG_COUNT*M_RAM_SEL_WIDTH-1:0]          ctrl_rd_cmd_sel,
  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0]           ctrl_rd_cmd_addr,
  input  logic [SEG_COUNT-1:0]                          ctrl_rd_cmd_valid,
  output logic [SEG_COUNT-1:0]                          ctrl_rd_cmd_ready,
  output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]           ctrl_rd_resp_data,
  output logic [SEG_COUNT-1:0]                          ctrl_rd_resp_valid,
  input  logic [SEG_COUNT-1:0]                          ctrl_rd_resp_ready,
  output logic [PORTS*SEG_COUNT*S_RAM_SEL_WIDTH-1:0]    ram_rd_cmd_sel,
  output logic [PORTS*SEG_COUNT*SEG_ADDR_WIDTH-1:0]     ram_rd_cmd_addr,
  output logic [PORTS*SEG_COUNT-1:0]                    ram_rd_cmd_valid,
  input  logic [PORTS*SEG_COUNT-1:0]                    ram_rd_cmd_ready,
  input  logic [PORTS*SEG_COUNT*SEG_DATA_WIDTH-1:0]     ram_rd_resp_data,
  input  logic [PORTS*SEG_COUNT-1:0]                    ram_rd_resp_valid,
  output logic [PORTS*SEG_COUNT-1:0]                    ram_rd_resp_ready,
  output logic [SEG_COUNT*($clog2(FIFO_DEPTH)+1)-1:0]   stat_outstanding,
  output logic                                          stat_sel_err
);
  localparam int PW = port_idx_w(PORTS);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int M  = M_RAM_SEL_WIDTH;
  localparam int S  = S_RAM_SEL_WIDTH;
  localparam int A  = SEG_ADDR_WIDTH;
  localparam int D  = SEG_DATA_WIDTH;

  if (!depth_ok(FIFO_DEPTH)) begin : g_depth_chk
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [SEG_COUNT-1:0] bad_sel;
  logic                 sel_err_q, sel_err_d;

  for (genvar s = 0; s < SEG_COUNT; s++) begin : g_seg
    logic [M-1:0]     sel;
    logic [PW-1:0]    port;
    logic [PW-1:0]    head;
    logic             port_ok, full, empty, push, pop;
    logic [PORTS-1:0] rdy_hit, vld_hit;
    logic [D-1:0]     resp_data;
    logic [CW-1:0]    count;

    assign sel = ctrl_rd_cmd_sel[s*M +: M];
    if (PORTS > 1) begin : g_idx
      assign port = sel[M-1 -: PW];
    end else begin : g_idx
      assign port = '0;
    end
    assign port_ok = 32'(port) < PORTS;

    // Address and select LSBs fan out to every port; only valid is steered.
    for (genvar p = 0; p < PORTS; p++) begin : g_port
      localparam int I = p*SEG_COUNT + s;
      assign rdy_hit[p]              = ram_rd_cmd_ready[I] && (32'(port) == p);
      assign vld_hit[p]              = ram_rd_resp_valid[I] && (32'(head) == p);
      assign ram_rd_cmd_valid[I]     = !rst && ctrl_rd_cmd_valid[s] && !full && port_ok
                                       && (32'(port) == p);
      assign ram_rd_cmd_sel[I*S +: S]  = sel[S-1:0];
      assign ram_rd_cmd_addr[I*A +: A] = ctrl_rd_cmd_addr[s*A +: A];
      assign ram_rd_resp_ready[I]    = !rst && !empty && (32'(head) == p) && ctrl_rd_resp_ready[s];
    end

    always_comb begin
      resp_data = '0;
      for (int unsigned p = 0; p < PORTS; p++) begin
        if (32'(head) == p) resp_data = ram_rd_resp_data[(p*SEG_COUNT + s)*D +: D];
      end
    end

    // Full is judged on registered occupancy, so a same-cycle pop never frees a slot.
    assign ctrl_rd_cmd_ready[s]          = !rst && (|rdy_hit) && !full && port_ok;
    assign ctrl_rd_resp_valid[s]         = !rst && !empty && (|vld_hit);
    assign ctrl_rd_resp_data[s*D +: D]   = resp_data;
    assign push                          = ctrl_rd_cmd_valid[s] && ctrl_rd_cmd_ready[s];
    assign pop                           = ctrl_rd_resp_valid[s] && ctrl_rd_resp_ready[s];
    assign bad_sel[s]                    = ctrl_rd_cmd_valid[s] && !port_ok;
    assign stat_outstanding[s*CW +: CW]  = count;

    dma_ram_demux_rd_order_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (PW),
      .CW    (CW)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (port),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (full),
      .empty_o     (empty),
      .count_o     (count)
    );
  end

  assign sel_err_d = sel_err_q || (|bad_sel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign stat_sel_err = sel_err_q;

endmodule

// File: tb/tb_dma_ram_demux_rd_ordered.sv
// Scoreboard bench for dma_ram_demux_rd_ordered with behavioural RAM models.
module tb_dma_ram_demux_rd_ordered;
  localparam int P = 3, SC = 2, D = 64, A = 8, S = 2, M = 4, DEP = 4, CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [SC*M-1:0]   ctrl_rd_cmd_sel;
  logic [SC*A-1:0]   ctrl_rd_cmd_addr;
  logic [SC-1:0]     ctrl_rd_cmd_valid, ctrl_rd_cmd_ready;
  logic [SC*D-1:0]   ctrl_rd_resp_data;
  logic [SC-1:0]     ctrl_rd_resp_valid, ctrl_rd_resp_ready;
  logic [P*SC*S-1:0] ram_rd_cmd_sel;
  logic [P*SC*A-1:0] ram_rd_cmd_addr;
  logic [P*SC-1:0]   ram_rd_cmd_valid, ram_rd_cmd_ready;
  logic [P*SC*D-1:0] ram_rd_resp_data;
  logic [P*SC-1:0]   ram_rd_resp_valid, ram_rd_resp_ready;
  logic [SC*CW-1:0]  stat_outstanding;
  logic              stat_sel_err;

  dma_ram_demux_rd_ordered #(
    .PORTS(P), .SEG_COUNT(SC), .SEG_DATA_WIDTH(D), .SEG_ADDR_WIDTH(A),
    .S_RAM_SEL_WIDTH(S), .M_RAM_SEL_WIDTH(M), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .rst(rst),
    .ctrl_rd_cmd_sel(ctrl_rd_cmd_sel), .ctrl_rd_cmd_addr(ctrl_rd_cmd_addr),
    .ctrl_rd_cmd_valid(ctrl_rd_cmd_valid), .ctrl_rd_cmd_ready(ctrl_rd_cmd_ready),
    .ctrl_rd_resp_data(ctrl_rd_resp_data), .ctrl_rd_resp_valid(ctrl_rd_resp_valid),
    .ctrl_rd_resp_ready(ctrl_rd_resp_ready),
    .ram_rd_cmd_sel(ram_rd_cmd_sel), .ram_rd_cmd_addr(ram_rd_cmd_addr),
    .ram_rd_cmd_valid(ram_rd_cmd_valid), .ram_rd_cmd_ready(ram_rd_cmd_ready),
    .ram_rd_resp_data(ram_rd_resp_data), .ram_rd_resp_valid(ram_rd_resp_valid),
    .ram_rd_resp_ready(ram_rd_resp_ready),
    .stat_outstanding(stat_outstanding), .stat_sel_err(stat_sel_err)
  );

  always #5 clk = ~clk;

  typedef struct { int port; logic [D-1:0] data; } exp_t;
  typedef struct { logic [D-1:0] data; int due; } rsp_t;
  typedef struct { int port; logic [S-1:0] lsb; logic [A-1:0] addr; } cmd_t;

  exp_t expq[SC][$];
  rsp_t ramq[P][SC][$];
  cmd_t cmdq[SC][$];

  int lat[P];
  bit lat_rand, rand_gen, rst_next, err_model;
  int rdy_pct, resp_pct[SC];
  int cyc, acc[SC], rsp_cnt[SC];
  int compared, mismatched;

  function automatic logic [D-1:0] mkdata(input int p, input int s,
                                          input logic [S-1:0] lsb, input logic [A-1:0] addr);
    return {16'hC0DE, 8'(p), 8'(s), 6'd0, lsb, addr, addr ^ 8'h5A, 8'hEF};
  endfunction

  function automatic cmd_t mkcmd(input int port);
    cmd_t c;
    c.port = port;
    c.lsb  = S'($urandom);
    c.addr = A'($urandom);
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle at negedge, then apply accepted handshakes to the models.
  task automatic step();
    int i;
    @(negedge clk);
    cyc++;
    if (rst_next && !rst) begin
      for (int s = 0; s < SC; s++) begin
        expq[s].delete();
        for (int p = 0; p < P; p++) ramq[p][s].delete();
      end
      err_model = 1'b0;
    end
    rst = rst_next;
    for (int s = 0; s < SC; s++) begin
      if (rand_gen && cmdq[s].size() < 2) cmdq[s].push_back(mkcmd(int'($urandom_range(P-1))));
      ctrl_rd_cmd_valid[s] = (cmdq[s].size() > 0) && (!rand_gen || $urandom_range(3) != 0);
      if (cmdq[s].size() > 0) begin
        ctrl_rd_cmd_sel[s*M +: M]  = {2'(cmdq[s][0].port), cmdq[s][0].lsb};
        ctrl_rd_cmd_addr[s*A +: A] = cmdq[s][0].addr;
      end else begin
        ctrl_rd_cmd_sel[s*M +: M]  = M'($urandom);
        ctrl_rd_cmd_addr[s*A +: A] = A'($urandom);
      end
      ctrl_rd_resp_ready[s] = $urandom_range(99) < resp_pct[s];
      for (int p = 0; p < P; p++) begin
        i = p*SC + s;
        ram_rd_cmd_ready[i] = $urandom_range(99) < rdy_pct;
        if (ramq[p][s].size() > 0 && ramq[p][s][0].due <= cyc) begin
          ram_rd_resp_valid[i]       = 1'b1;
          ram_rd_resp_data[i*D +: D] = ramq[p][s][0].data;
        end else begin
          ram_rd_resp_valid[i]       = 1'b0;
          ram_rd_resp_data[i*D +: D] = {$urandom, $urandom};
        end
      end
    end
    #2;
    if (!rst) begin
      for (int s = 0; s < SC; s++) begin
        for (int p = 0; p < P; p++) begin
          rsp_t r;
          i = p*SC + s;
          if (ram_rd_resp_valid[i] && ram_rd_resp_ready[i]) void'(ramq[p][s].pop_front());
          if (ram_rd_cmd_valid[i] && ram_rd_cmd_ready[i]) begin
            r.data = mkdata(p, s, ram_rd_cmd_sel[i*S +: S], ram_rd_cmd_addr[i*A +: A]);
            r.due  = cyc + (lat_rand ? int'($urandom_range(6, 1)) : lat[p]);
            ramq[p][s].push_back(r);
          end
        end
        if (ctrl_rd_cmd_valid[s] && cmdq[s][0].port >= P) err_model = 1'b1;
        if (ctrl_rd_cmd_valid[s] && ctrl_rd_cmd_ready[s]) begin
          cmd_t c;
          exp_t e;
          c = cmdq[s].pop_front();
          e.port = c.port;
          e.data = mkdata(c.port, s, c.lsb, c.addr);
          expq[s].push_back(e);
          acc[s]++;
        end
      end
    end
  endtask

  // Monitor: protocol expectations from the ordering model, plus response scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int s = 0; s < SC; s++) begin
        int n, pp, hd;
        exp_t e;
        n  = expq[s].size();
        pp = int'(ctrl_rd_cmd_sel[s*M+S +: 2]);
        if (rst) begin
          chk($sformatf("rst_cmd_ready[%0d]", s), ctrl_rd_cmd_ready[s], 0);
          chk($sformatf("rst_resp_valid[%0d]", s), ctrl_rd_resp_valid[s], 0);
          chk($sformatf("rst_outstanding[%0d]", s), stat_outstanding[s*CW +: CW], 0);
          for (int p = 0; p < P; p++) begin
            chk($sformatf("rst_ram_cmd_valid[%0d][%0d]", p, s), ram_rd_cmd_valid[p*SC+s], 0);
            chk($sformatf("rst_ram_resp_ready[%0d][%0d]", p, s), ram_rd_resp_ready[p*SC+s], 0);
          end
        end else begin
          hd = (n > 0) ? expq[s][0].port : -1;
          chk($sformatf("outstanding[%0d]", s), stat_outstanding[s*CW +: CW], n);
          chk($sformatf("cmd_ready[%0d]", s), ctrl_rd_cmd_ready[s],
              (pp < P) ? (n < DEP && ram_rd_cmd_ready[pp*SC+s]) : 1'b0);
          chk($sformatf("resp_valid[%0d]", s), ctrl_rd_resp_valid[s],
              (hd >= 0) ? ram_rd_resp_valid[hd*SC+s] : 1'b0);
          for (int p = 0; p < P; p++) begin
            chk($sformatf("ram_cmd_valid[%0d][%0d]", p, s), ram_rd_cmd_valid[p*SC+s],
                ctrl_rd_cmd_valid[s] && n < DEP && p == pp);
            chk($sformatf("ram_resp_ready[%0d][%0d]", p, s), ram_rd_resp_ready[p*SC+s],
                p == hd && ctrl_rd_resp_ready[s]);
          end
          if (ctrl_rd_resp_valid[s] && ctrl_rd_resp_ready[s]) begin
            if (n == 0) begin
              compared++;
              mismatched++;
              $display("FAIL unexpected_resp[%0d]: got response expected none (cycle %0d)", s, cyc);
            end else begin
              e = expq[s].pop_front();
              chk($sformatf("resp_data[%0d]", s), ctrl_rd_resp_data[s*D +: D], e.data);
              rsp_cnt[s]++;
            end
          end
        end
      end
      chk("sel_err", stat_sel_err, err_model);
    end
  end

  initial begin
    int a, r;
    ctrl_rd_cmd_valid = '0; ctrl_rd_cmd_sel = '0; ctrl_rd_cmd_addr = '0; ctrl_rd_resp_ready = '0;
    ram_rd_cmd_ready = '0; ram_rd_resp_valid = '0; ram_rd_resp_data = '0;
    rst_next = 1'b1; rdy_pct = 100; resp_pct[0] = 100; resp_pct[1] = 100;
    lat[0] = 5; lat[1] = 1; lat[2] = 1;
    repeat (3) step();
    rst_next = 1'b0;
    step();

    // Slow port 0 and fast port 1 interleaved: responses must stay in command order.
    r = rsp_cnt[0];
    cmdq[0].push_back(mkcmd(0)); cmdq[0].push_back(mkcmd(1));
    cmdq[0].push_back(mkcmd(0)); cmdq[0].push_back(mkcmd(1));
    repeat (30) step();
    chk("order_resp_count", rsp_cnt[0] - r, 4);

    // Fill the FIFO with responses blocked; fifth command must stall.
    resp_pct[0] = 0;
    for (int k = 0; k < 5; k++) cmdq[0].push_back(mkcmd(k % 2));
    repeat (10) step();
    chk("full_outstanding", stat_outstanding[0 +: CW], 4);
    chk("full_ready", ctrl_rd_cmd_ready[0], 0);
    chk("full_pending", cmdq[0].size(), 1);

    // Same-cycle pop while full: pop completes, command still refused.
    a = acc[0]; r = rsp_cnt[0];
    resp_pct[0] = 100;
    step();
    chk("full_pop_done", rsp_cnt[0] - r, 1);
    chk("full_no_push_on_pop", acc[0] - a, 0);
    step();
    chk("full_push_next", acc[0] - a, 1);
    repeat (30) step();

    // Segment 0 stalled; segment 1 keeps one command and one response per cycle.
    lat[0] = 1;
    resp_pct[0] = 0;
    for (int k = 0; k < 3; k++) cmdq[0].push_back(mkcmd(k));
    for (int k = 0; k < 40; k++) cmdq[1].push_back(mkcmd(int'($urandom_range(P-1))));
    a = acc[1]; r = rsp_cnt[1];
    repeat (40) step();
    chk("seg1_cmd_rate", acc[1] - a, 40);
    chk("seg1_resp_rate", rsp_cnt[1] - r, 39);
    resp_pct[0] = 100;
    repeat (10) step();

    // Port index 3 with three ports: stalls forever and flags a sticky error.
    cmdq[1].push_back(mkcmd(3));
    repeat (8) step();
    chk("selerr_flag", stat_sel_err, 1);
    chk("selerr_pending", cmdq[1].size(), 1);
    cmdq[1].delete();
    repeat (3) step();
    chk("selerr_sticky", stat_sel_err, 1);

    // Reset with three reads outstanding, then a fresh read.
    resp_pct[0] = 0;
    for (int k = 0; k < 3; k++) cmdq[0].push_back(mkcmd(k));
    repeat (6) step();
    chk("prerst_outstanding", stat_outstanding[0 +: CW], 3);
    rst_next = 1'b1;
    step();
    chk("rst_outstanding_now", stat_outstanding[0 +: CW], 0);
    chk("rst_selerr_clear", stat_sel_err, 0);
    step();
    rst_next = 1'b0;
    resp_pct[0] = 100;
    step();
    r = rsp_cnt[0];
    cmdq[0].push_back(mkcmd(1));
    repeat (10) step();
    chk("postrst_resp", rsp_cnt[0] - r, 1);

    // Randomised traffic with random latencies and back-pressure, then drain.
    lat_rand = 1'b1; rand_gen = 1'b1; rdy_pct = 70; resp_pct[0] = 70; resp_pct[1] = 70;
    repeat (400) step();
    rand_gen = 1'b0; rdy_pct = 100; resp_pct[0] = 100; resp_pct[1] = 100;
    for (int s = 0; s < SC; s++) cmdq[s].delete();
    repeat (60) step();
    chk("drain_seg0", stat_outstanding[0 +: CW], 0);
    chk("drain_seg1", stat_outstanding[CW +: CW], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
